// File: rtl/fp_cvt96_to32_pipe_pkg.sv
// Shared FP96/FP32 types, rounding-mode encoding and exponent constants
// for the FP96 -> FP32 down-converter.
package fp_cvt96_to32_pipe_pkg;

  typedef struct packed {
    logic        sign;
    logic [14:0] exp;
    logic [79:0] frac;
  } fp96_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // FP96 bias (16383) minus FP32 bias (127)
  localparam int unsigned BIAS96_32_DIFF = 16256;
  localparam logic [14:0] EXP96_MAX      = 15'h7FFF;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } fp_rm_t;

  typedef enum logic [1:0] {
    K_FIN  = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } fp_kind_t;

endpackage

// File: rtl/fp_round32.sv
// Combinational FP32 rounder: sign, 9b exponent field, 24b mantissa and G/R/S in,
// rounded FP32 out. The o_flags port exists only when FP_CVT96_32_EXC_EN is defined.
module fp_round32
  import fp_cvt96_to32_pipe_pkg::*;
(
  input  logic        i_sign,
  input  logic [8:0]  i_exp,
  input  logic [23:0] i_mant,
  input  logic        i_g,
  input  logic        i_r,
  input  logic        i_s,
  input  fp_rm_t      i_rm,
  output fp32_t       o_res
`ifdef FP_CVT96_32_EXC_EN
  ,
  output logic [4:0]  o_flags
`endif
);

  logic        w_lost;
  logic        w_inc;
  logic        w_to_inf;
  logic [8:0]  w_exp_in;
  logic [31:0] w_sum;
  logic        w_ovf;

  assign w_lost = i_g | i_r | i_s;

  // An exponent field of 0 with the hidden bit set is the value 2^-126 (field 1).
  assign w_exp_in = (i_exp == 9'd0) ? {8'd0, i_mant[23]} : i_exp;

  // Rounding into {exp,frac} lets a mantissa carry ripple straight into the exponent.
  assign w_sum = {w_exp_in, i_mant[22:0]} + {31'd0, w_inc};
  assign w_ovf = (w_sum[31:23] >= 9'd255);

  always_comb begin
    w_inc    = 1'b0;
    w_to_inf = 1'b1;
    case (i_rm)
      RTZ: begin
        w_inc    = 1'b0;
        w_to_inf = 1'b0;
      end
      RDN: begin
        w_inc    = i_sign & w_lost;
        w_to_inf = i_sign;
      end
      RUP: begin
        w_inc    = ~i_sign & w_lost;
        w_to_inf = ~i_sign;
      end
      RMM:     w_inc = i_g;
      default: w_inc = i_g & (i_r | i_s | i_mant[0]);
    endcase
  end

  always_comb begin
    if (w_ovf) begin
      o_res = w_to_inf ? {i_sign, 8'hFF, 23'd0} : {i_sign, 8'hFE, 23'h7FFFFF};
    end else begin
      o_res = {i_sign, w_sum[30:0]};
    end
  end

`ifdef FP_CVT96_32_EXC_EN
  assign o_flags = {2'b00, w_ovf, ~w_ovf & (w_sum[30:23] == 8'd0) & w_lost, w_lost | w_ovf};
`endif

endmodule

// File: rtl/fp_cvt96_to32_pipe.sv
// FP96 -> FP32 down-converter: 3-stage valid/ready pipeline (unpack, align, round).
// Define FP_CVT96_32_EXC_EN to build the exception flags; otherwise o_exc is tied to 0.
module fp_cvt96_to32_pipe
  import fp_cvt96_to32_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [95:0] i,
  input  logic [2:0]  rm,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o,
  output logic [4:0]  o_exc
);

  fp96_t              w_in;
  logic               w_adv;
  fp_kind_t           w_kind1;
  logic signed [16:0] w_e1;

  logic               r_v1;
  logic               r_s1_sign;
  fp_kind_t           r_s1_kind;
  logic signed [16:0] r_s1_e;
  logic [80:0]        r_s1_v;
  fp_rm_t             r_s1_rm;

  logic [4:0]         w_sh;
  logic [106:0]       w_wide;
  logic [8:0]         w_exp2;
  logic [23:0]        w_mant2;
  logic               w_g2;
  logic               w_r2;
  logic               w_s2;

  logic               r_v2;
  logic               r_s2_sign;
  fp_kind_t           r_s2_kind;
  logic [8:0]         r_s2_exp;
  logic [23:0]        r_s2_mant;
  logic               r_s2_g;
  logic               r_s2_r;
  logic               r_s2_s;
  fp_rm_t             r_s2_rm;
  logic [21:0]        r_s2_payload;

  fp32_t              w_rnd;
  fp32_t              w_res3;
  logic               r_v3;
  logic [31:0]        r_o;

`ifdef FP_CVT96_32_EXC_EN
  logic               r_s2_snan;
  logic [4:0]         w_flags;
  logic [4:0]         w_exc3;
  logic [4:0]         r_exc;
`endif

  assign w_in    = i;
  assign w_adv   = ~r_v3 | o_ready;
  assign i_ready = w_adv & ~rst;
  assign o_valid = r_v3;
  assign o       = r_o;

  // S1: classify and rebias; e is the FP32 biased exponent, possibly out of range
  assign w_e1 = $signed({2'b00, w_in.exp} - 17'(BIAS96_32_DIFF));

  always_comb begin
    if (w_in.exp == EXP96_MAX) begin
      if (w_in.frac != 80'd0) w_kind1 = K_NAN;
      else                    w_kind1 = K_INF;
    end else if ((w_in.exp == 15'd0) && (w_in.frac == 80'd0)) begin
      w_kind1 = K_ZERO;
    end else begin
      w_kind1 = K_FIN;
    end
  end

  // S2: shifts past 26 leave only sticky, so the distance is capped there
  assign w_sh   = (r_s1_e < -17'sd24) ? 5'd26 : 5'(17'sd1 - r_s1_e);
  assign w_wide = {r_s1_v, 26'd0} >> w_sh;

  always_comb begin
    if (r_s1_e <= 17'sd0) begin
      w_exp2  = 9'd0;
      w_mant2 = w_wide[106:83];
      w_g2    = w_wide[82];
      w_r2    = w_wide[81];
      w_s2    = |w_wide[80:0];
    end else begin
      w_exp2  = (r_s1_e >= 17'sd255) ? 9'd255 : r_s1_e[8:0];
      w_mant2 = r_s1_v[80:57];
      w_g2    = r_s1_v[56];
      w_r2    = r_s1_v[55];
      w_s2    = |r_s1_v[54:0];
    end
  end

  fp_round32 u_round (
    .i_sign  (r_s2_sign),
    .i_exp   (r_s2_exp),
    .i_mant  (r_s2_mant),
    .i_g     (r_s2_g),
    .i_r     (r_s2_r),
    .i_s     (r_s2_s),
    .i_rm    (r_s2_rm),
    .o_res   (w_rnd)
`ifdef FP_CVT96_32_EXC_EN
    ,
    .o_flags (w_flags)
`endif
  );

  always_comb begin
    case (r_s2_kind)
      K_NAN:   w_res3 = {r_s2_sign, 8'hFF, 1'b1, r_s2_payload};
      K_INF:   w_res3 = {r_s2_sign, 8'hFF, 23'd0};
      K_ZERO:  w_res3 = {r_s2_sign, 31'd0};
      default: w_res3 = w_rnd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1         <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_kind    <= K_FIN;
      r_s1_e       <= '0;
      r_s1_v       <= '0;
      r_s1_rm      <= RNE;
      r_v2         <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_kind    <= K_FIN;
      r_s2_exp     <= '0;
      r_s2_mant    <= '0;
      r_s2_g       <= 1'b0;
      r_s2_r       <= 1'b0;
      r_s2_s       <= 1'b0;
      r_s2_rm      <= RNE;
      r_s2_payload <= '0;
      r_v3         <= 1'b0;
      r_o          <= '0;
    end else if (w_adv) begin
      r_v1         <= i_valid;
      r_s1_sign    <= w_in.sign;
      r_s1_kind    <= w_kind1;
      r_s1_e       <= w_e1;
      r_s1_v       <= {1'b1, w_in.frac};
      r_s1_rm      <= fp_rm_t'(rm);
      r_v2         <= r_v1;
      r_s2_sign    <= r_s1_sign;
      r_s2_kind    <= r_s1_kind;
      r_s2_exp     <= w_exp2;
      r_s2_mant    <= w_mant2;
      r_s2_g       <= w_g2;
      r_s2_r       <= w_r2;
      r_s2_s       <= w_s2;
      r_s2_rm      <= r_s1_rm;
      r_s2_payload <= r_s1_v[78:57];
      r_v3         <= r_v2;
      r_o          <= w_res3;
    end
  end

`ifdef FP_CVT96_32_EXC_EN
  // Specials raise nothing except invalid for a signalling NaN
  always_comb begin
    w_exc3 = 5'd0;
    if (r_s2_kind == K_NAN)      w_exc3 = {r_s2_snan, 4'd0};
    else if (r_s2_kind == K_FIN) w_exc3 = w_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_snan <= 1'b0;
      r_exc     <= '0;
    end else if (w_adv) begin
      r_s2_snan <= ~r_s1_v[79];
      r_exc     <= w_exc3;
    end
  end

  assign o_exc = r_exc;
`else
  assign o_exc = 5'd0;
`endif

endmodule

// File: tb/tb_fp_cvt96_to32_pipe.sv
// Bench for fp_cvt96_to32_pipe: directed spec cases, streaming/stall, reset, and
// random traffic scored against an integer-arithmetic rounding model.
module tb_fp_cvt96_to32_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [95:0] i = '0;
  logic [2:0]  rm = '0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [31:0] o;
  logic [4:0]  o_exc;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

`ifdef FP_CVT96_32_EXC_EN
  localparam logic [4:0] EXC_MASK = 5'h1F;
`else
  localparam logic [4:0] EXC_MASK = 5'h00;
`endif

  always #5 clk = ~clk;

  fp_cvt96_to32_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i       (i),
    .rm      (rm),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o       (o),
    .o_exc   (o_exc)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value = M * 2^(u-80), M = {1,frac}; keep k low bits according to
  // the FP32 quantum (2^(u-23) normal, 2^-149 subnormal) and round the integer quotient.
  function automatic logic [36:0] ref_cvt(input logic [95:0] x, input logic [2:0] r);
    logic          s;
    logic [14:0]   ex;
    logic [79:0]   fr;
    logic [255:0]  mm, q, rem, half;
    int            u, ue, k, rmode;
    logic          up, inx, inf_sel;
    logic [31:0]   res;
    s  = x[95];
    ex = x[94:80];
    fr = x[79:0];
    rmode = (r > 3'd4) ? 0 : int'(r);
    if (ex == 15'h7FFF) begin
      if (fr != 80'd0) return {~fr[79], 4'b0000, s, 8'hFF, 1'b1, fr[78:57]};
      return {5'b00000, s, 8'hFF, 23'd0};
    end
    if (ex == 15'd0 && fr == 80'd0) return {5'b00000, s, 31'd0};
    mm = {175'd0, 1'b1, fr};
    u  = int'(ex) - 16383;
    ue = u + 127;
    k  = (ue >= 1) ? 57 : (-69 - u);
    if (k > 200) k = 200;
    q    = mm >> k;
    rem  = mm - (q << k);
    half = 256'd1 << (k - 1);
    inx  = (rem != 256'd0);
    case (rmode)
      0:       up = (rem > half) || ((rem == half) && q[0]);
      1:       up = 1'b0;
      2:       up = s && inx;
      3:       up = !s && inx;
      default: up = (rem >= half);
    endcase
    q = q + {255'd0, up};
    if (ue >= 1 && q == (256'd1 << 24)) begin
      ue = ue + 1;
      q  = 256'd1 << 23;
    end
    if (ue >= 255) begin
      case (rmode)
        1:       inf_sel = 1'b0;
        2:       inf_sel = s;
        3:       inf_sel = !s;
        default: inf_sel = 1'b1;
      endcase
      res = inf_sel ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
      return {5'b00101, res};
    end
    if (ue >= 1) res = {s, 8'(ue), q[22:0]};
    else         res = {s, q[30:0]};
    return {3'b000, inx && (res[30:23] == 8'd0), inx, res};
  endfunction

  function automatic logic [95:0] rand_op();
    logic [79:0] f;
    logic [14:0] ex;
    int          sel;
    f   = {$urandom, $urandom, 16'($urandom)};
    sel = $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) f[55:0] = 56'd0;
    case (sel)
      0:          ex = 15'h7FFF;
      1:          begin ex = 15'h7FFF; f = 80'd0; end
      2:          begin ex = 15'd0;    f = 80'd0; end
      3, 4, 5, 6: ex = 15'(16226 + $urandom_range(0, 31));
      7, 8, 9:    ex = 15'(16506 + $urandom_range(0, 10));
      default:    ex = 15'(16257 + $urandom_range(0, 252));
    endcase
    return {1'($urandom), ex, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Samples the handshake just after the negedge, scores any delivered result,
  // then advances one full clock back to the next negedge.
  task automatic step(output bit acc, output bit pop, output logic [31:0] po, output logic [4:0] pe);
    logic [36:0] e;
    #1;
    acc = i_valid && i_ready;
    pop = o_valid && o_ready;
    po  = o;
    pe  = o_exc;
    if (acc) exp_q.push_back(ref_cvt(i, rm));
    if (pop) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL spurious_output: observed %h expected none", o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_data", o, e[31:0]);
        chk("stream_exc", {27'd0, o_exc}, {27'd0, e[36:32] & EXC_MASK});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [95:0] x, input logic [2:0] r,
                         input logic [31:0] eo, input logic [4:0] ee);
    bit          a, p, got;
    logic [31:0] po;
    logic [4:0]  pe;
    got = 1'b0;
    i = x; rm = r; i_valid = 1'b1; o_ready = 1'b1;
    step(a, p, po, pe);
    chk({tag, "_accept"}, {31'd0, a}, 32'd1);
    i_valid = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(a, p, po, pe);
      if (p) got = 1'b1;
    end
    chk({tag, "_done"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, "_o"}, po, eo);
      chk({tag, "_exc"}, {27'd0, pe}, {27'd0, ee & EXC_MASK});
    end
  endtask

  initial begin
    bit          a, p;
    logic [31:0] po, held;
    logic [4:0]  pe;
    logic [95:0] strm[6];
    int          n, npop;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ovalid", {31'd0, o_valid}, 32'd0);
    chk("rst_o", o, 32'd0);
    chk("rst_exc", {27'd0, o_exc}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_iready", {31'd0, i_ready}, 32'd1);
    @(negedge clk);

    // 1.0 with exact 3-clock latency
    i = {1'b0, 15'h3FFF, 80'd0}; rm = 3'd0; i_valid = 1'b1; o_ready = 1'b1;
    step(a, p, po, pe);
    chk("lat_accept", {31'd0, a}, 32'd1);
    i_valid = 1'b0;
    step(a, p, po, pe);
    chk("lat_c1", {31'd0, p}, 32'd0);
    step(a, p, po, pe);
    chk("lat_c2", {31'd0, p}, 32'd0);
    step(a, p, po, pe);
    chk("lat_c3", {31'd0, p}, 32'd1);
    chk("one_o", po, 32'h3F800000);
    chk("one_exc", {27'd0, pe}, 32'd0);

    run_one("tie_rne", {1'b0, 15'h3FFF, 23'd0, 1'b1, 56'd0}, 3'd0, 32'h3F800000, 5'b00001);
    run_one("tie_rup", {1'b0, 15'h3FFF, 23'd0, 1'b1, 56'd0}, 3'd3, 32'h3F800001, 5'b00001);
    run_one("tie_rdn", {1'b0, 15'h3FFF, 23'd0, 1'b1, 56'd0}, 3'd2, 32'h3F800000, 5'b00001);
    run_one("ovf_rne", {1'b0, 15'h4080, 80'd0}, 3'd0, 32'h7F800000, 5'b00101);
    run_one("ovf_rtz", {1'b0, 15'h4080, 80'd0}, 3'd1, 32'h7F7FFFFF, 5'b00101);
    run_one("ovf_neg_rup", {1'b1, 15'h4080, 80'd0}, 3'd3, 32'hFF7FFFFF, 5'b00101);
    run_one("snan", {1'b0, 15'h7FFF, 80'd1}, 3'd0, 32'h7FC00000, 5'b10000);
    run_one("neg_inf", {1'b1, 15'h7FFF, 80'd0}, 3'd0, 32'hFF800000, 5'b00000);
    run_one("neg_zero", {1'b1, 15'h0000, 80'd0}, 3'd0, 32'h80000000, 5'b00000);
    run_one("sub_min", {1'b0, 15'h3F6A, 80'd0}, 3'd0, 32'h00000001, 5'b00000);
    run_one("sub_tie", {1'b0, 15'h3F69, 80'd0}, 3'd0, 32'h00000000, 5'b00011);

    // Streaming with a 5-clock output stall
    for (int k = 0; k < 6; k++) strm[k] = {1'b0, 15'(16383 + k), $urandom, $urandom, 16'($urandom)};
    n = 0; npop = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      if (n < 6) begin i_valid = 1'b1; i = strm[n]; rm = 3'(c % 5); end
      else i_valid = 1'b0;
      o_ready = (c >= 5);
      if (c == 3 || c == 4) begin
        #1;
        chk("stall_iready", {31'd0, i_ready}, 32'd0);
        chk("stall_inflight", n, 3);
        chk("stall_ovalid", {31'd0, o_valid}, 32'd1);
        if (c == 3) held = o;
        else        chk("stall_hold", o, held);
      end
      step(a, p, po, pe);
      if (a) n++;
      if (p) npop++;
      if (n == 6 && exp_q.size() == 0) break;
    end
    chk("stream_accepted", n, 6);
    chk("stream_popped", npop, 6);
    chk("stream_drained", exp_q.size(), 0);

    // Random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      i       = rand_op();
      rm      = 3'($urandom_range(0, 7));
      step(a, p, po, pe);
    end
    i_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(a, p, po, pe);
    chk("rand_drained", exp_q.size(), 0);

    // Reset in the middle of a stream
    o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'b1; i = rand_op(); rm = 3'd0;
      step(a, p, po, pe);
    end
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("midrst_ovalid", {31'd0, o_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    npop = 0;
    for (int c = 0; c < 10; c++) begin
      step(a, p, po, pe);
      if (p) npop++;
    end
    chk("midrst_no_stale", npop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
